// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage.
// Control-word layout, access sizes and FSM states.
package mem_stage_pkg;

  localparam int CTRL_RD_HI  = 11;
  localparam int CTRL_RD_LO  = 7;
  localparam int CTRL_REG_WE = 6;
  localparam int CTRL_RSVD   = 5;
  localparam int CTRL_MEM_RD = 4;
  localparam int CTRL_MEM_WR = 3;
  localparam int CTRL_SZ_HI  = 2;
  localparam int CTRL_SZ_LO  = 1;
  localparam int CTRL_UNSIGN = 0;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } mem_state_e;

endpackage

// File: rtl/tracer_interface.sv
// Trace record handed from stage to stage.
// Sink side reads, source side drives.
interface tracer_interface;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] mem_data;

  modport sink (
    input valid, pc, instr, mem_data
  );
  modport source (
    output valid, pc, instr, mem_data
  );
endinterface

// File: rtl/memory_stage_load_store_aligner.sv
// Lane steering for sub-word loads and stores.
// Purely combinational; also flags misaligned accesses.
module load_store_aligner
  import mem_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   addr_i,
  input  mem_size_e    sz_i,
  input  logic         unsigned_i,
  input  logic [W-1:0] sdata_i,
  input  logic [W-1:0] rdata_i,
  output logic [3:0]   be_o,
  output logic [W-1:0] wdata_o,
  output logic [W-1:0] ldata_o,
  output logic         misal_o
);

  logic [W-1:0] sh;

  assign sh = rdata_i >> {addr_i, 3'b000};

  // Decode size into enables, replicated data and extended load
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = sdata_i;
    ldata_o = rdata_i;
    misal_o = 1'b0;
    unique case (sz_i)
      MEM_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{sdata_i[7:0]}};
        ldata_o = unsigned_i ? {24'h0, sh[7:0]}
                             : {{24{sh[7]}}, sh[7:0]};
      end
      MEM_HALF: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{sdata_i[15:0]}};
        ldata_o = unsigned_i ? {16'h0, sh[15:0]}
                             : {{16{sh[15]}}, sh[15:0]};
        misal_o = addr_i[0];
      end
      MEM_WORD: begin
        be_o    = 4'b1111;
        misal_o = |addr_i;
      end
      MEM_ILL: begin
        misal_o = 1'b1;
      end
      default: misal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: data-memory access FSM,
// stall generation and the MEM/WB register.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] calculated_result_i,
  input  logic [size-1:0] store_data_i,
  input  logic [11:0]     control_signal_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [size-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [size-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [size-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic            misaligned_o,
  output logic [size-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_we_o,
  tracer_interface.sink   tracer_if_i,
  tracer_interface.source tracer_if_o
);

  logic            rd_en, wr_en, reg_we, mem_op;
  logic            is_load, go, bad_acc;
  logic            misal, retire, ld_ret;
  logic            unused_rsvd;
  logic [size-1:0] ldata;
  mem_size_e       msz;
  mem_state_e      state_q, state_d;
  logic            tr_valid_q;
  logic [31:0]     tr_pc_q, tr_instr_q, tr_mem_q;

  assign rd_en   = control_signal_i[CTRL_MEM_RD];
  assign wr_en   = control_signal_i[CTRL_MEM_WR];
  assign reg_we  = control_signal_i[CTRL_REG_WE];
  assign msz     = mem_size_e'(control_signal_i[CTRL_SZ_HI:CTRL_SZ_LO]);
  assign mem_op  = rd_en | wr_en;
  assign is_load = rd_en;
  assign bad_acc = mem_op & misal;
  assign go      = mem_op & ~misal;
  assign unused_rsvd = control_signal_i[CTRL_RSVD];

  load_store_aligner #(.W(size)) u_align (
    .addr_i     (calculated_result_i[1:0]),
    .sz_i       (msz),
    .unsigned_i (control_signal_i[CTRL_UNSIGN]),
    .sdata_i    (store_data_i),
    .rdata_i    (dmem_rdata_i),
    .be_o       (dmem_be_o),
    .wdata_o    (dmem_wdata_o),
    .ldata_o    (ldata),
    .misal_o    (misal)
  );

  assign dmem_we_o   = ~is_load;
  assign dmem_addr_o = {calculated_result_i[size-1:2], 2'b00};
  assign ld_ret      = (state_q == WAIT_RVALID) & dmem_rvalid_i;
  assign stall_o     = ~retire;

  // Request, retire and next-state decode
  always_comb begin
    dmem_req_o = 1'b0;
    retire     = 1'b0;
    state_d    = state_q;
    unique case (state_q)
      IDLE: begin
        dmem_req_o = go;
        retire     = ~go | (dmem_gnt_i & ~is_load);
        if (go & dmem_gnt_i & is_load)
          state_d = WAIT_RVALID;
        else if (go & ~dmem_gnt_i)
          state_d = WAIT_GNT;
      end
      WAIT_GNT: begin
        dmem_req_o = 1'b1;
        retire     = dmem_gnt_i & ~is_load;
        if (dmem_gnt_i)
          state_d = is_load ? WAIT_RVALID : IDLE;
      end
      WAIT_RVALID: begin
        retire = dmem_rvalid_i;
        if (dmem_rvalid_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and MEM/WB register; bubble while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wb_data_o    <= '0;
      wb_rd_o      <= '0;
      wb_we_o      <= 1'b0;
      misaligned_o <= 1'b0;
      tr_valid_q   <= 1'b0;
      tr_pc_q      <= '0;
      tr_instr_q   <= '0;
      tr_mem_q     <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        wb_data_o    <= ld_ret ? ldata : calculated_result_i;
        wb_rd_o      <= control_signal_i[CTRL_RD_HI:CTRL_RD_LO];
        wb_we_o      <= reg_we & ~bad_acc & (is_load | ~wr_en);
        misaligned_o <= bad_acc;
        tr_valid_q   <= tracer_if_i.valid;
        tr_pc_q      <= tracer_if_i.pc;
        tr_instr_q   <= tracer_if_i.instr;
        tr_mem_q     <= ld_ret ? ldata : tracer_if_i.mem_data;
      end else begin
        wb_we_o      <= 1'b0;
        misaligned_o <= 1'b0;
        tr_valid_q   <= 1'b0;
      end
    end
  end

  assign tracer_if_o.valid    = tr_valid_q;
  assign tracer_if_o.pc       = tr_pc_q;
  assign tracer_if_o.instr    = tr_instr_q;
  assign tracer_if_o.mem_data = tr_mem_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage.
// Hand-computed vectors through a single check task.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] calc, sdata, rdata;
  logic [11:0] ctrl;
  logic        gnt, rvalid;
  logic        req, we, stall, misal, wb_we;
  logic [31:0] addr, wdata, wb_data;
  logic [3:0]  be;
  logic [4:0]  wb_rd;
  int          total = 0;
  int          bad = 0;

  tracer_interface tr_in ();
  tracer_interface tr_out ();

  always #5 clk = ~clk;

  memory_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .calculated_result_i (calc),
    .store_data_i        (sdata),
    .control_signal_i    (ctrl),
    .dmem_req_o          (req),
    .dmem_we_o           (we),
    .dmem_addr_o         (addr),
    .dmem_be_o           (be),
    .dmem_wdata_o        (wdata),
    .dmem_gnt_i          (gnt),
    .dmem_rvalid_i       (rvalid),
    .dmem_rdata_i        (rdata),
    .stall_o             (stall),
    .misaligned_o        (misal),
    .wb_data_o           (wb_data),
    .wb_rd_o             (wb_rd),
    .wb_we_o             (wb_we),
    .tracer_if_i         (tr_in),
    .tracer_if_o         (tr_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctrl = {rd, reg_we, rsvd, mem_rd, mem_wr, size, unsigned}
  function automatic logic [11:0] mk(input logic [4:0] rd,
                                     input logic rw,
                                     input logic mr,
                                     input logic mw,
                                     input logic [1:0] sz,
                                     input logic un);
    return {rd, rw, 1'b0, mr, mw, sz, un};
  endfunction

  task automatic nop();
    ctrl = 12'h000;
    calc = 32'h0;
    gnt = 1'b0;
    rvalid = 1'b0;
  endtask

  task automatic byte_load(input logic un,
                           input logic [31:0] exp);
    ctrl = mk(5'd7, 1'b1, 1'b1, 1'b0, 2'b00, un);
    calc = 32'h101;
    gnt = 1'b1;
    #1;
    chk("ldb_req", {31'h0, req}, 32'h1);
    chk("ldb_stall0", {31'h0, stall}, 32'h1);
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 32'h0000_8000;
    #1;
    chk("ldb_req_off", {31'h0, req}, 32'h0);
    chk("ldb_stall1", {31'h0, stall}, 32'h0);
    chk("ldb_bubble", {31'h0, wb_we}, 32'h0);
    tick();
    nop();
    chk("ldb_data", wb_data, exp);
    chk("ldb_we", {31'h0, wb_we}, 32'h1);
    chk("ldb_rd", {27'h0, wb_rd}, 32'd7);
    chk("ldb_trmem", tr_out.mem_data, exp);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    sdata = 32'h0;
    rdata = 32'h0;
    nop();
    tr_in.valid = 1'b1;
    tr_in.pc = 32'h0000_0400;
    tr_in.instr = 32'h0000_0013;
    tr_in.mem_data = 32'h0000_0055;
    #12;
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_we", {31'h0, wb_we}, 32'h0);
    chk("rst_tr_valid", {31'h0, tr_out.valid}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ALU result passes straight through
    ctrl = mk(5'd3, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    calc = 32'h1234;
    #1;
    chk("alu_stall", {31'h0, stall}, 32'h0);
    chk("alu_req", {31'h0, req}, 32'h0);
    tick();
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_we", {31'h0, wb_we}, 32'h1);
    chk("alu_rd", {27'h0, wb_rd}, 32'd3);
    chk("alu_trv", {31'h0, tr_out.valid}, 32'h1);
    chk("alu_trpc", tr_out.pc, 32'h400);
    chk("alu_trmem", tr_out.mem_data, 32'h55);

    // Store byte, same-cycle grant
    ctrl = mk(5'd5, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    calc = 32'h103;
    sdata = 32'h0000_00AB;
    gnt = 1'b1;
    #1;
    chk("sb_be", {28'h0, be}, 32'h8);
    chk("sb_wdata", wdata, 32'hABAB_ABAB);
    chk("sb_addr", addr, 32'h100);
    chk("sb_req", {31'h0, req}, 32'h1);
    chk("sb_we", {31'h0, we}, 32'h1);
    chk("sb_stall", {31'h0, stall}, 32'h0);
    tick();
    nop();
    chk("sb_wb_we", {31'h0, wb_we}, 32'h0);
    chk("sb_trv", {31'h0, tr_out.valid}, 32'h1);

    byte_load(1'b0, 32'hFFFF_FF80);
    byte_load(1'b1, 32'h0000_0080);

    // Word load: grant after 3 cycles, rvalid 2 later
    ctrl = mk(5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    calc = 32'h200;
    rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 6; c++) begin
      gnt = (c == 3);
      rvalid = (c == 5);
      #1;
      chk("lw_stall", {31'h0, stall}, {31'h0, c < 5});
      chk("lw_req", {31'h0, req}, {31'h0, c <= 3});
      if (c <= 3)
        chk("lw_addr", addr, 32'h200);
      tick();
      if (c < 5)
        chk("lw_no_wb", {31'h0, wb_we}, 32'h0);
    end
    nop();
    chk("lw_data", wb_data, 32'hDEAD_BEEF);
    chk("lw_we", {31'h0, wb_we}, 32'h1);
    tick();
    chk("lw_single", {31'h0, wb_we}, 32'h0);

    // Half load at 0x102: aligned, upper lanes
    ctrl = mk(5'd4, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    calc = 32'h102;
    gnt = 1'b1;
    #1;
    chk("lh_be", {28'h0, be}, 32'hC);
    chk("lh_req", {31'h0, req}, 32'h1);
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hABCD_1234;
    tick();
    chk("lh_data", wb_data, 32'hFFFF_ABCD);
    chk("lh_we", {31'h0, wb_we}, 32'h1);

    // Half load at 0x203: misaligned, suppressed
    ctrl = mk(5'd4, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    calc = 32'h203;
    gnt = 1'b0;
    rvalid = 1'b0;
    #1;
    chk("mis_req", {31'h0, req}, 32'h0);
    chk("mis_stall", {31'h0, stall}, 32'h0);
    tick();
    nop();
    chk("mis_pulse", {31'h0, misal}, 32'h1);
    chk("mis_we", {31'h0, wb_we}, 32'h0);
    tick();
    chk("mis_pulse_end", {31'h0, misal}, 32'h0);

    // Reset while waiting for rvalid
    ctrl = mk(5'd6, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    calc = 32'h300;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    #1;
    chk("rw_stall", {31'h0, stall}, 32'h1);
    nop();
    reset = 1'b0;
    #2;
    chk("rw_rst_data", wb_data, 32'h0);
    chk("rw_rst_rd", {27'h0, wb_rd}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rvalid = 1'b1;
    rdata = 32'h1111_2222;
    #1;
    chk("rw_stall_post", {31'h0, stall}, 32'h0);
    chk("rw_req_post", {31'h0, req}, 32'h0);
    tick();
    rvalid = 1'b0;
    chk("rw_wb_we", {31'h0, wb_we}, 32'h0);
    chk("rw_wb_data", wb_data, 32'h0);
    chk("rw_mis", {31'h0, misal}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage, directly downstream of the execute stage. Consumes the EX/MEM register outputs (ALU result or address, store data, 12-bit control word). Performs byte/half/word loads and stores over a req/gnt/rvalid data-memory bus and stalls the pipeline while an access is outstanding. Drives the MEM/WB pipeline register and the trace record for the write-back stage.

## Interface
- `size`, 32: datapath width.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low.
- `calculated_result_i` in `size`: ALU result, or memory address for loads/stores.
- `store_data_i` in `size`: forwarded rs2 store data.
- `control_signal_i` in 12: fields are
  - [11:7] rd
  - [6] reg_write
  - [5] reserved, ignored
  - [4] mem_read
  - [3] mem_write
  - [2:1] size: 00 byte, 01 half, 10 word, 11 illegal
  - [0] load_unsigned
- `dmem_req_o` out 1: request valid.
- `dmem_we_o` out 1: 1 = store.
- `dmem_addr_o` out `size`: word-aligned address, {addr[31:2], 2'b00}.
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out `size`: lane-replicated store data.
- `dmem_gnt_i` in 1: request accepted.
- `dmem_rvalid_i` in 1: read data valid.
- `dmem_rdata_i` in `size`: read word.
- `stall_o` out 1: hold all upstream stages.
- `misaligned_o` out 1, registered: pulse, access suppressed.
- `wb_data_o` out `size`, registered: write-back data.
- `wb_rd_o` out 5, registered: destination register.
- `wb_we_o` out 1, registered: register write enable.
- `tracer_if_i` sink / `tracer_if_o` source, `tracer_interface`: trace record pass-through.

## Operation
- Misaligned access: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - No request is issued.
  - `misaligned_o` pulses for 1 cycle.
  - `wb_we_o` is 0 for that instruction.
- Non-memory instruction: passes to the MEM/WB register with `wb_data_o` = `calculated_result_i`. No stall.
- Store byte enables:
  - byte: 1 << addr[1:0]
  - half: 0011 or 1100
  - word: 1111
- Store data: byte replicated ×4, half replicated ×2.
- Load extraction: select lane by addr[1:0], then sign-extend, or zero-extend if load_unsigned.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
  - IDLE, aligned mem op: `dmem_req_o`=1 combinationally.
    - gnt=0 → WAIT_GNT.
    - gnt=1 and store → retire, stay IDLE.
    - gnt=1 and load → WAIT_RVALID.
  - WAIT_GNT: request held with address, data, be and we stable.
    - gnt=1 → store retires to IDLE, load goes to WAIT_RVALID.
  - WAIT_RVALID: `dmem_req_o`=0.
    - rvalid=1 → capture extracted data into `wb_data_o`, `wb_we_o`=reg_write, go to IDLE.
- `stall_o` is combinational. It is 1 when either holds:
  - in IDLE with an aligned mem op that is not retiring this cycle;
  - in WAIT_GNT or WAIT_RVALID, except the retiring cycle.
- Upstream holds `*_i` stable while `stall_o`=1.
- While stalled, the MEM/WB register loads a bubble: `wb_we_o`=0, and tracer valid=0.
- Tracer:
  - `mem_data` is replaced with the extracted load data on load retire.
  - All other fields are copied on retire.

## Timing
- All outputs reset to 0, and the FSM resets to IDLE.
- `reset` asserted mid-access: outstanding access abandoned, no write-back, any late rvalid ignored.
- Latency:
  - Non-mem and store with same-cycle gnt: 1 cycle to MEM/WB, 0 stall cycles.
  - Load with same-cycle gnt and rvalid next cycle: 1 stall cycle, write-back on the rvalid edge.
- rvalid in IDLE or WAIT_GNT is a protocol error and is ignored.
- Per-cycle priority:
  1. reset
  2. FSM transition
  3. MEM/WB capture
- A misaligned instruction never enters WAIT_GNT.

## Structure
- Shared package `mem_stage_pkg`:
  - control-field bit positions
  - size encodings (MEM_BYTE, MEM_HALF, MEM_WORD)
  - FSM state enum
- Sub-module `load_store_aligner`, combinational:
  - inputs: addr[1:0], size, unsigned flag, store data, read word
  - outputs: be, lane-replicated wdata, extended load data, misaligned flag
- FSM and pipeline registers live in the top-level module.

## Test plan
- ALU op, result 0x1234 → 0x1234 to MEM/WB: `wb_data_o`=0x1234 and `wb_we_o`=1 next edge, `stall_o`=0 throughout.
- Store byte 0xAB at addr 0x103 (rd=5 unused), gnt same cycle → `dmem_be_o`=1000, `dmem_wdata_o`=0xABABABAB, `dmem_addr_o`=0x100, no stall.
- Signed byte load at addr 0x101 with rdata 0x0000_8000, gnt same cycle, rvalid next cycle → 1 stall cycle, `wb_data_o`=0xFFFFFF80. Repeat as unsigned load → 0x00000080.
- Word load with gnt delayed 3 cycles and rvalid 2 cycles later → `stall_o`=1 for 5 cycles, req/addr stable while waiting, single write-back.
- Half load at addr 0x102 → valid access, be=1100. Half load at addr 0x203 → `misaligned_o` pulse, no req, `wb_we_o`=0.
- `reset` asserted in WAIT_RVALID, rvalid arrives after release → FSM in IDLE, all outputs 0, no write-back.
